// File: rtl/avg_sched_if.sv
// Bundle of the requester and datapath signals around the averaging scheduler.
// The scheduler connects through the slave modport and its environment through master.
interface avg_sched_if #(
   parameter int NUM_REQ    = 4,
   parameter int NUM_INPUTS = 16,
   parameter int DWIDTH     = 8
);
   logic [NUM_REQ-1:0]                   i_en_mask;
   logic [NUM_REQ-1:0]                   i_req_valid;
   logic [NUM_REQ*NUM_INPUTS*DWIDTH-1:0] i_req_data;
   logic [NUM_REQ-1:0]                   o_req_ready;
   logic [NUM_INPUTS*DWIDTH-1:0]         o_dat_vector;
   logic                                 o_dat_valid;
   logic [DWIDTH-1:0]                    i_avg;
   logic                                 i_avg_valid;
   logic [DWIDTH-1:0]                    o_rsp_avg;
   logic [NUM_REQ-1:0]                   o_rsp_valid;
   logic                                 o_busy;
   logic                                 o_err;

   modport slave (
      input  i_en_mask, i_req_valid, i_req_data, i_avg, i_avg_valid,
      output o_req_ready, o_dat_vector, o_dat_valid, o_rsp_avg, o_rsp_valid,
             o_busy, o_err
   );

   modport master (
      output i_en_mask, i_req_valid, i_req_data, i_avg, i_avg_valid,
      input  o_req_ready, o_dat_vector, o_dat_valid, o_rsp_avg, o_rsp_valid,
             o_busy, o_err
   );
endinterface

// File: rtl/avg_sched.sv
// Round-robin scheduler sharing one averaging datapath among NUM_REQ requesters.
// An in-order tag FIFO remembers who issued each in-flight vector so results
// can be steered back to their owner; the FIFO depth doubles as the credit limit.
module avg_sched #(
   parameter int NUM_REQ    = 4,
   parameter int NUM_INPUTS = 16,
   parameter int DWIDTH     = 8,
   parameter int DEPTH      = 4
) (
   input logic         clk,
   input logic         rst_n,
   avg_sched_if.slave  bus
);
   localparam int VW   = NUM_INPUTS * DWIDTH;
   localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = AW + 1;

   logic [IDXW-1:0]    ptr_q, ptr_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [AW-1:0]      wr_q, rd_q;
   logic [IDXW-1:0]    tag_q [DEPTH];
   logic [VW-1:0]      dat_vec_q;
   logic               dat_vld_q;
   logic [DWIDTH-1:0]  rsp_avg_q;
   logic [NUM_REQ-1:0] rsp_vld_q, rsp_vld_d;
   logic               err_q;

   logic [NUM_REQ-1:0] elig, grant;
   logic               credit_ok, any_elig, push, pop, spurious;
   logic [IDXW-1:0]    gnt_idx, head;
   logic [IDXW:0]      scan;
   logic [VW-1:0]      sel_vec;

   assign elig      = bus.i_req_valid & bus.i_en_mask;
   // A result arriving this cycle frees a slot, so a full FIFO may still accept.
   assign credit_ok = (cnt_q < CW'(DEPTH)) || ((cnt_q == CW'(DEPTH)) && bus.i_avg_valid);
   assign any_elig  = |elig;
   assign head      = tag_q[rd_q];
   assign pop       = bus.i_avg_valid && (cnt_q != '0);
   assign spurious  = bus.i_avg_valid && (cnt_q == '0);

   // Round-robin pick: scan offsets high to low so the nearest eligible one above ptr wins.
   always_comb begin
      gnt_idx = '0;
      scan    = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         scan = {1'b0, ptr_q} + (IDXW+1)'(i);
         if (scan >= (IDXW+1)'(NUM_REQ)) scan = scan - (IDXW+1)'(NUM_REQ);
         if (elig[scan[IDXW-1:0]]) gnt_idx = scan[IDXW-1:0];
      end
   end

   // One-hot grant gated by credit.
   always_comb begin
      grant = '0;
      for (int r = 0; r < NUM_REQ; r++)
         grant[r] = credit_ok && any_elig && (gnt_idx == IDXW'(r));
   end

   assign push    = |grant;
   assign sel_vec = bus.i_req_data[gnt_idx*VW +: VW];

   // Next pointer, occupancy and response strobe.
   always_comb begin
      ptr_d = ptr_q;
      if (push) ptr_d = (gnt_idx == IDXW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDXW'(1);
      cnt_d = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
      rsp_vld_d = '0;
      for (int r = 0; r < NUM_REQ; r++)
         rsp_vld_d[r] = pop && (head == IDXW'(r));
   end

   // Control and output registers; reset discards all in-flight tags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q     <= '0;
         cnt_q     <= '0;
         wr_q      <= '0;
         rd_q      <= '0;
         dat_vec_q <= '0;
         dat_vld_q <= 1'b0;
         rsp_avg_q <= '0;
         rsp_vld_q <= '0;
         err_q     <= 1'b0;
      end else begin
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         dat_vld_q <= push;
         rsp_vld_q <= rsp_vld_d;
         if (push) begin
            dat_vec_q <= sel_vec;
            wr_q      <= wr_q + AW'(1);
         end
         if (pop) begin
            rsp_avg_q <= bus.i_avg;
            rd_q      <= rd_q + AW'(1);
         end
         if (spurious) err_q <= 1'b1;
      end
   end

   // Tag storage; at full with push+pop the head is read before the slot is reused.
   always_ff @(posedge clk) begin
      if (push) tag_q[wr_q] <= gnt_idx;
   end

   assign bus.o_req_ready  = rst_n ? grant : '0;
   assign bus.o_dat_vector = dat_vec_q;
   assign bus.o_dat_valid  = dat_vld_q;
   assign bus.o_rsp_avg    = rsp_avg_q;
   assign bus.o_rsp_valid  = rsp_vld_q;
   assign bus.o_busy       = (cnt_q != '0);
   assign bus.o_err        = err_q;
endmodule

// File: tb/tb_avg_sched.sv
// Directed bench for avg_sched: fairness, credit limit, routing, masking,
// spurious results and asynchronous reset.
module tb_avg_sched;
   localparam int NR = 4;
   localparam int NI = 16;
   localparam int DW = 8;
   localparam int DP = 4;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errs   = 0;

   logic [NI*DW-1:0] exp_vec;
   logic [3:0]       exp_g;
   logic [7:0]       bv;
   logic [3:0]       mgrant [4];

   avg_sched_if #(.NUM_REQ(NR), .NUM_INPUTS(NI), .DWIDTH(DW)) bus ();

   avg_sched #(.NUM_REQ(NR), .NUM_INPUTS(NI), .DWIDTH(DW), .DEPTH(DP)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [NI*DW-1:0] obs,
                      input logic [NI*DW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
      bus.i_req_data = {{16{b3}}, {16{b2}}, {16{b1}}, {16{b0}}};
   endtask

   task automatic clear_inputs();
      bus.i_en_mask   = 4'b1111;
      bus.i_req_valid = 4'b0000;
      bus.i_avg       = 8'h00;
      bus.i_avg_valid = 1'b0;
      set_data(8'h11, 8'h22, 8'h33, 8'h44);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      step();
      step();
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      mgrant[0] = 4'b0001; mgrant[1] = 4'b0010; mgrant[2] = 4'b1000; mgrant[3] = 4'b0001;

      rst_n = 1'b0;
      clear_inputs();
      bus.i_req_valid = 4'b1111;
      step();
      chk("rst_ready", bus.o_req_ready, 4'b0000);
      chk("rst_dat_valid", bus.o_dat_valid, 1'b0);
      chk("rst_rsp_valid", bus.o_rsp_valid, 4'b0000);
      chk("rst_dat_vector", bus.o_dat_vector, {(NI*DW){1'b0}});
      chk("rst_rsp_avg", bus.o_rsp_avg, 8'h00);
      chk("rst_busy", bus.o_busy, 1'b0);
      chk("rst_err", bus.o_err, 1'b0);
      do_reset();

      bus.i_req_valid = 4'b1111;
      for (int c = 0; c < 6; c++) begin
         bus.i_avg_valid = (c > 0);
         bus.i_avg       = 8'(c + 1);
         #1;
         exp_g = 4'b0001 << (c % 4);
         chk("fair_ready", bus.o_req_ready, exp_g);
         step();
         bv = 8'(8'h11 * ((c % 4) + 1));
         exp_vec = {16{bv}};
         chk("fair_dat_valid", bus.o_dat_valid, 1'b1);
         chk("fair_dat_vector", bus.o_dat_vector, exp_vec);
         if (c > 0) begin
            exp_g = 4'b0001 << ((c - 1) % 4);
            chk("fair_rsp_valid", bus.o_rsp_valid, exp_g);
            chk("fair_rsp_avg", bus.o_rsp_avg, 8'(c + 1));
         end else begin
            chk("fair_rsp_none", bus.o_rsp_valid, 4'b0000);
         end
      end
      bus.i_req_valid = 4'b0000;
      bus.i_avg       = 8'h77;
      bus.i_avg_valid = 1'b1;
      step();
      chk("fair_drain_rsp", bus.o_rsp_valid, 4'b0010);
      chk("fair_drain_avg", bus.o_rsp_avg, 8'h77);
      chk("fair_drain_dat_valid", bus.o_dat_valid, 1'b0);
      chk("fair_drain_busy", bus.o_busy, 1'b0);
      bus.i_avg_valid = 1'b0;
      step();
      chk("fair_rsp_hold_valid", bus.o_rsp_valid, 4'b0000);
      chk("fair_rsp_hold_avg", bus.o_rsp_avg, 8'h77);
      chk("fair_no_err", bus.o_err, 1'b0);

      do_reset();
      bus.i_req_valid = 4'b1111;
      #1;
      chk("cred_g0", bus.o_req_ready, 4'b0001);
      step();
      bus.i_req_valid = 4'b1110;
      #1;
      chk("cred_g1", bus.o_req_ready, 4'b0010);
      step();
      bus.i_req_valid = 4'b1100;
      #1;
      chk("cred_g2", bus.o_req_ready, 4'b0100);
      step();
      bus.i_req_valid = 4'b1000;
      #1;
      chk("cred_g3", bus.o_req_ready, 4'b1000);
      step();
      bus.i_req_valid = 4'b1111;
      #1;
      chk("cred_full_ready", bus.o_req_ready, 4'b0000);
      chk("cred_full_busy", bus.o_busy, 1'b1);
      bus.i_avg       = 8'h55;
      bus.i_avg_valid = 1'b1;
      #1;
      chk("cred_same_cycle_grant", bus.o_req_ready, 4'b0001);
      step();
      chk("cred_rsp_valid", bus.o_rsp_valid, 4'b0001);
      chk("cred_rsp_avg", bus.o_rsp_avg, 8'h55);
      chk("cred_dat_valid", bus.o_dat_valid, 1'b1);
      bus.i_avg_valid = 1'b0;
      #1;
      chk("cred_still_full", bus.o_req_ready, 4'b0000);
      bus.i_req_valid = 4'b0000;
      bus.i_avg_valid = 1'b1;
      for (int d = 0; d < 4; d++) begin
         bus.i_avg = 8'(8'hA0 + d);
         step();
         exp_g = 4'b0001 << ((d + 1) % 4);
         chk("cred_drain_rsp", bus.o_rsp_valid, exp_g);
         chk("cred_drain_avg", bus.o_rsp_avg, 8'(8'hA0 + d));
      end
      bus.i_avg_valid = 1'b0;
      chk("cred_drain_busy", bus.o_busy, 1'b0);
      chk("cred_no_err", bus.o_err, 1'b0);

      do_reset();
      set_data(8'h00, 8'h20, 8'h10, 8'h00);
      bus.i_req_valid = 4'b0100;
      #1;
      chk("route_g2", bus.o_req_ready, 4'b0100);
      step();
      chk("route_vec2", bus.o_dat_vector, {16{8'h10}});
      bus.i_req_valid = 4'b0010;
      #1;
      chk("route_g1", bus.o_req_ready, 4'b0010);
      step();
      chk("route_vec1", bus.o_dat_vector, {16{8'h20}});
      bus.i_req_valid = 4'b0000;
      bus.i_avg       = 8'h10;
      bus.i_avg_valid = 1'b1;
      step();
      chk("route_rsp2", bus.o_rsp_valid, 4'b0100);
      chk("route_avg2", bus.o_rsp_avg, 8'h10);
      bus.i_avg = 8'h20;
      step();
      chk("route_rsp1", bus.o_rsp_valid, 4'b0010);
      chk("route_avg1", bus.o_rsp_avg, 8'h20);
      bus.i_avg_valid = 1'b0;

      do_reset();
      bus.i_en_mask   = 4'b1011;
      bus.i_req_valid = 4'b1111;
      for (int c = 0; c < 4; c++) begin
         bus.i_avg_valid = (c > 0);
         bus.i_avg       = 8'(8'h30 + c);
         #1;
         chk("mask_ready", bus.o_req_ready, mgrant[c]);
         step();
         if (c > 0) begin
            chk("mask_rsp", bus.o_rsp_valid, mgrant[c-1]);
         end
      end

      do_reset();
      bus.i_avg       = 8'hEE;
      bus.i_avg_valid = 1'b1;
      step();
      chk("spur_err", bus.o_err, 1'b1);
      chk("spur_no_rsp", bus.o_rsp_valid, 4'b0000);
      chk("spur_busy", bus.o_busy, 1'b0);
      bus.i_avg_valid = 1'b0;
      step();
      chk("spur_sticky", bus.o_err, 1'b1);
      bus.i_req_valid = 4'b1111;
      step();
      bus.i_avg       = 8'h99;
      bus.i_avg_valid = 1'b1;
      step();
      chk("burst_rsp_avg", bus.o_rsp_avg, 8'h99);
      chk("burst_busy", bus.o_busy, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_dat_valid", bus.o_dat_valid, 1'b0);
      chk("arst_rsp_valid", bus.o_rsp_valid, 4'b0000);
      chk("arst_dat_vector", bus.o_dat_vector, {(NI*DW){1'b0}});
      chk("arst_rsp_avg", bus.o_rsp_avg, 8'h00);
      chk("arst_busy", bus.o_busy, 1'b0);
      chk("arst_err", bus.o_err, 1'b0);
      chk("arst_ready", bus.o_req_ready, 4'b0000);
      step();
      rst_n = 1'b1;
      bus.i_req_valid = 4'b0000;
      bus.i_avg_valid = 1'b1;
      step();
      chk("post_rst_err", bus.o_err, 1'b1);
      chk("post_rst_no_rsp", bus.o_rsp_valid, 4'b0000);
      bus.i_avg_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/avg_sched.md
AVG_SCHED -- requirements
Module: avg_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one averaging datapath (>=2).
REQ-002 Parameter NUM_INPUTS, default 16, samples per request vector (power of 2).
REQ-003 Parameter DWIDTH, default 8, bits per sample and per average.
REQ-004 Parameter DEPTH, default 4, maximum requests in flight in the datapath (power of 2, >=2).
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 i_en_mask  input  NUM_REQ  per-requester enable; a masked requester is never granted.
REQ-008 i_req_valid  input  NUM_REQ  per-requester request valid.
REQ-009 i_req_data  input  NUM_REQ*NUM_INPUTS*DWIDTH  requester r owns slice [r*NUM_INPUTS*DWIDTH +: NUM_INPUTS*DWIDTH].
REQ-010 o_req_ready  output  NUM_REQ  grant; at most one bit is high per cycle.
REQ-011 o_dat_vector  output  NUM_INPUTS*DWIDTH  vector forwarded to the datapath.
REQ-012 o_dat_valid  output  1  datapath input valid.
REQ-013 i_avg  input  DWIDTH  datapath result.
REQ-014 i_avg_valid  input  1  datapath result valid.
REQ-015 o_rsp_avg  output  DWIDTH  result returned to the owning requester.
REQ-016 o_rsp_valid  output  NUM_REQ  one-hot response strobe.
REQ-017 o_busy  output  1  high while the in-flight count is nonzero.
REQ-018 o_err  output  1  sticky error flag.

Function
REQ-019 Eligible set = i_req_valid & i_en_mask; o_req_ready is combinational from eligible, pointer and credit.
REQ-020 Round-robin: grant the first eligible requester found scanning upward from ptr, wrapping from NUM_REQ-1 to 0.
REQ-021 On a grant to k, ptr <= (k+1) mod NUM_REQ; with no grant, ptr holds.
REQ-022 Transfer occurs when i_req_valid[k] & o_req_ready[k]; at most one transfer per cycle.
REQ-023 Credit: a grant is allowed only when count < DEPTH, or when count == DEPTH and i_avg_valid is high in the same cycle.
REQ-024 On a transfer, o_dat_vector <= slice k and o_dat_valid <= 1 on the next edge (1-cycle latency); otherwise o_dat_valid <= 0 and o_dat_vector holds.
REQ-025 On a transfer, requester index k is pushed into an in-order tag FIFO of DEPTH entries (width clog2(NUM_REQ)).
REQ-026 On i_avg_valid with a nonempty FIFO, the head tag t is popped; the next edge sets o_rsp_avg <= i_avg and o_rsp_valid <= one-hot(t) for exactly 1 cycle.
REQ-027 With no result, o_rsp_valid <= 0 and o_rsp_avg holds.
REQ-028 count (clog2(DEPTH)+1 bits) increments on push only, decrements on pop only, and holds on simultaneous push and pop.
REQ-029 FIFO pointers wrap modulo DEPTH.
REQ-030 Simultaneous push and pop at count == DEPTH is legal; count stays DEPTH.
REQ-031 i_avg_valid with count == 0: set o_err <= 1, produce no response, and leave count at 0.
REQ-032 o_err clears only on reset.
REQ-033 Clearing an i_en_mask bit affects only future grants; that requester's in-flight results are still returned.
REQ-034 A requester may hold i_req_valid across cycles; data must stay stable until ready.

Reset
REQ-035 While rst_n is low, immediately: o_dat_valid=0, o_rsp_valid=0, o_dat_vector=0, o_rsp_avg=0, o_busy=0, o_err=0, ptr=0, count=0, FIFO pointers=0.
REQ-036 Reset during operation discards in-flight tags; datapath results arriving after reset with count 0 set o_err per REQ-031.
REQ-037 o_req_ready is 0 while rst_n is low.

Verification (NUM_REQ=4, NUM_INPUTS=16, DWIDTH=8, DEPTH=4)
REQ-038 Fairness: all four requesters valid continuously with immediate results -> grants 0,1,2,3,0,... with no requester skipped.
REQ-039 Credit limit: results withheld and requesters 0-3 each issue one request -> 4 transfers, then o_req_ready=0; next i_avg_valid (i_avg=0x55) -> o_rsp_valid=4'b0001 and o_rsp_avg=0x55 one cycle later, and a grant in the same cycle as that result.
REQ-040 Routing: requester 2 sends all 0x10 and requester 1 sends all 0x20, in that order -> results 0x10 then 0x20 delivered on o_rsp_valid 4'b0100 then 4'b0010.
REQ-041 Mask: i_en_mask=4'b1011 with all requesters valid -> requester 2 never granted; order 0,1,3,0.
REQ-042 Spurious result: i_avg_valid with count=0 -> o_err=1 sticky, no o_rsp_valid; deassert rst_n mid-burst -> all outputs and o_err are 0 asynchronously.
